// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the 16-bit TSC CPU: steps one shared memory port and ALU through IF/ID/EX/MEM/WB.
// Latency (memory always ready): jumps/WWD/HLT 2 cycles, branches 3, ALU ops and SWD 4, LWD 5.
// Backpressure: IF and MEM hold with stable strobes until mem_ready (only when MEM_HANDSHAKE_EN is defined).
//
// Ports:
//   clk, reset_n        - clock (rising edge), asynchronous active-low reset
//   instr               - instruction register contents (opcode [15:12], func [5:0])
//   mem_ready           - memory completes the current access this cycle
//   pc_*/ir_write/...   - combinational datapath strobes decoded from state, instr, mem_ready
//   inst_done           - one-cycle pulse on the last cycle of each instruction
//   is_halted, state    - registered halt flag and current state (debug)
//
// Build option: MEM_HANDSHAKE_EN. When undefined, mem_ready is ignored and every
// memory state lasts exactly one cycle.
module multicycle_control_fsm #(
    parameter int WORD_SIZE = 16,
    parameter int STATE_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] instr,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_source,
    output logic                 ir_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 pc_to_reg,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 output_write,
    output logic                 inst_done,
    output logic                 is_halted,
    output logic [STATE_W-1:0]   state
);

    typedef enum logic [STATE_W-1:0] {
        S_IF   = STATE_W'(0),
        S_ID   = STATE_W'(1),
        S_EX   = STATE_W'(2),
        S_MEM  = STATE_W'(3),
        S_WB   = STATE_W'(4),
        S_HALT = STATE_W'(5)
    } state_t;

    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    localparam logic [5:0] FN_JPR = 6'd25;
    localparam logic [5:0] FN_JRL = 6'd26;
    localparam logic [5:0] FN_WWD = 6'd28;
    localparam logic [5:0] FN_HLT = 6'd29;

    state_t state_q, state_d;
    logic   halted_q;

    logic mem_rdy;
`ifdef MEM_HANDSHAKE_EN
    assign mem_rdy = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_rdy          = 1'b1;
`endif

    // Register-field bits are consumed by the datapath, not by the sequencer.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr[WORD_SIZE-5:6];

    logic [3:0] opcode;
    logic [5:0] func;
    assign opcode = instr[WORD_SIZE-1 -: 4];
    assign func   = instr[5:0];

    logic is_branch, is_mem, is_imm, is_r, r_alu;
    logic is_jpr, is_jrl, is_wwd, is_hlt, needs_ex;
    assign is_branch = (opcode[3:2] == 2'b00);
    assign is_mem    = (opcode == OP_LWD) || (opcode == OP_SWD);
    assign is_imm    = (opcode == OP_ADI) || (opcode == OP_ORI) || (opcode == OP_LHI);
    assign is_r      = (opcode == OP_R);
    assign r_alu     = is_r && (func[5:3] == 3'b000);
    assign is_jpr    = is_r && (func == FN_JPR);
    assign is_jrl    = is_r && (func == FN_JRL);
    assign is_wwd    = is_r && (func == FN_WWD);
    assign is_hlt    = is_r && (func == FN_HLT);
    assign needs_ex  = is_branch || is_mem || is_imm || r_alu;

    logic       pc_write_c, pc_write_cond_c, ir_write_c, i_or_d_c;
    logic       mem_read_c, mem_write_c, mem_to_reg_c, reg_write_c;
    logic       pc_to_reg_c, alu_src_a_c, output_write_c, inst_done_c;
    logic [1:0] pc_source_c, alu_src_b_c, alu_op_c;

    always_comb begin
        state_d         = state_q;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        pc_source_c     = 2'd0;
        ir_write_c      = 1'b0;
        i_or_d_c        = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        mem_to_reg_c    = 1'b0;
        reg_write_c     = 1'b0;
        pc_to_reg_c     = 1'b0;
        alu_src_a_c     = 1'b0;
        alu_src_b_c     = 2'd0;
        alu_op_c        = 2'd0;
        output_write_c  = 1'b0;
        inst_done_c     = 1'b0;

        case (state_q)
            S_IF: begin
                // ALU computes PC+1 while the fetch is outstanding.
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'd1;
                if (mem_rdy) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_ID;
                end
            end
            S_ID: begin
                // ALU computes PC+imm into the branch-target register.
                alu_src_b_c = 2'd2;
                if ((opcode == OP_JMP) || (opcode == OP_JAL)) begin
                    pc_write_c  = 1'b1;
                    pc_source_c = 2'd2;
                    reg_write_c = (opcode == OP_JAL);
                    pc_to_reg_c = (opcode == OP_JAL);
                    inst_done_c = 1'b1;
                    state_d     = S_IF;
                end else if (is_jpr || is_jrl) begin
                    pc_write_c  = 1'b1;
                    pc_source_c = 2'd3;
                    reg_write_c = is_jrl;
                    pc_to_reg_c = is_jrl;
                    inst_done_c = 1'b1;
                    state_d     = S_IF;
                end else if (is_wwd) begin
                    output_write_c = 1'b1;
                    inst_done_c    = 1'b1;
                    state_d        = S_IF;
                end else if (is_hlt) begin
                    inst_done_c = 1'b1;
                    state_d     = S_HALT;
                end else if (needs_ex) begin
                    state_d = S_EX;
                end else begin
                    // Undefined encodings retire as a NOP.
                    inst_done_c = 1'b1;
                    state_d     = S_IF;
                end
            end
            S_EX: begin
                if (is_branch) begin
                    alu_src_a_c     = 1'b1;
                    alu_op_c        = 2'd1;
                    pc_write_cond_c = 1'b1;
                    pc_source_c     = 2'd1;
                    inst_done_c     = 1'b1;
                    state_d         = S_IF;
                end else if (is_mem) begin
                    alu_src_a_c = 1'b1;
                    alu_src_b_c = 2'd2;
                    state_d     = S_MEM;
                end else if (r_alu) begin
                    alu_src_a_c = 1'b1;
                    alu_op_c    = 2'd2;
                    state_d     = S_WB;
                end else if (opcode == OP_ADI) begin
                    alu_src_a_c = 1'b1;
                    alu_src_b_c = 2'd2;
                    alu_op_c    = 2'd2;
                    state_d     = S_WB;
                end else if (is_imm) begin
                    alu_src_a_c = 1'b1;
                    alu_src_b_c = 2'd3;
                    alu_op_c    = 2'd2;
                    state_d     = S_WB;
                end else begin
                    // Unreachable from ID; retire rather than lock up.
                    inst_done_c = 1'b1;
                    state_d     = S_IF;
                end
            end
            S_MEM: begin
                i_or_d_c    = 1'b1;
                mem_read_c  = (opcode == OP_LWD);
                mem_write_c = (opcode == OP_SWD);
                if (mem_rdy) begin
                    if (opcode == OP_SWD) begin
                        inst_done_c = 1'b1;
                        state_d     = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = (opcode == OP_LWD);
                inst_done_c  = 1'b1;
                state_d      = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_q || (state_d == S_HALT);
        end
    end

    // Strobes are masked during reset so an abandoned instruction writes nothing.
    assign pc_write      = reset_n & pc_write_c;
    assign pc_write_cond = reset_n & pc_write_cond_c;
    assign pc_source     = reset_n ? pc_source_c : 2'd0;
    assign ir_write      = reset_n & ir_write_c;
    assign i_or_d        = reset_n & i_or_d_c;
    assign mem_read      = reset_n & mem_read_c;
    assign mem_write     = reset_n & mem_write_c;
    assign mem_to_reg    = reset_n & mem_to_reg_c;
    assign reg_write     = reset_n & reg_write_c;
    assign pc_to_reg     = reset_n & pc_to_reg_c;
    assign alu_src_a     = reset_n & alu_src_a_c;
    assign alu_src_b     = reset_n ? alu_src_b_c : 2'd0;
    assign alu_op        = reset_n ? alu_op_c : 2'd0;
    assign output_write  = reset_n & output_write_c;
    assign inst_done     = reset_n & inst_done_c;
    assign is_halted     = halted_q;
    assign state         = state_q;

endmodule
